// File: rtl/vga_timing_pkg.sv
// 800x600@72 raster constants, coordinate/colour types and shared helpers
// for the timing generator and the on-screen overlay blocks.
package vga_timing_pkg;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 3;

  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FRONT   = 56;
  localparam int VGA_H_SYNC    = 120;
  localparam int VGA_H_BACK    = 64;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FRONT   = 37;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_BACK    = 23;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK   = 3'b000;
  localparam color_t BLUE    = 3'b001;
  localparam color_t GREEN   = 3'b010;
  localparam color_t CYAN    = 3'b011;
  localparam color_t RED     = 3'b100;
  localparam color_t MAGENTA = 3'b101;
  localparam color_t YELLOW  = 3'b110;
  localparam color_t WHITE   = 3'b111;

  // Raw timing decoded from one counter pair; all-zero is the blank/inactive state.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } timing_t;

  function automatic logic in_range(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// PIPE-deep register chain for the raw {act, hs, vs} timing, cleared to blank.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  timing_t d,
  output timing_t q
);
  timing_t [PIPE-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[PIPE-1];
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: free-running pixel/line counters, sync and blanking
// delayed to match the overlay pipeline, and the final colour composite.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int     H_VISIBLE = VGA_H_VISIBLE,
  parameter int     H_FRONT   = VGA_H_FRONT,
  parameter int     H_SYNC    = VGA_H_SYNC,
  parameter int     H_BACK    = VGA_H_BACK,
  parameter int     V_VISIBLE = VGA_V_VISIBLE,
  parameter int     V_FRONT   = VGA_V_FRONT,
  parameter int     V_SYNC    = VGA_V_SYNC,
  parameter int     V_BACK    = VGA_V_BACK,
  parameter bit     SYNC_POL  = 1'b1,
  parameter int     PIPE      = 1,
  parameter color_t BG        = BLACK
) (
  input  logic   clk,
  input  logic   reset,
  output coord_t vga_h,
  output coord_t vga_v,
  input  color_t pixel_in,
  input  logic   pixel_on,
  output logic   hsync,
  output logic   vsync,
  output color_t rgb,
  output logic   video_active,
  output logic   frame_start
);
  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic    h_last, v_last;
  timing_t raw, dly;

  assign h_last = (vga_h == H_LAST);
  assign v_last = (vga_v == V_LAST);

  // frame_start is loaded from the wrap condition so it is high exactly
  // while the counters present 0,0.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_h       <= '0;
      vga_v       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_h       <= h_last ? '0 : vga_h + 11'd1;
      if (h_last) vga_v <= v_last ? '0 : vga_v + 11'd1;
      frame_start <= h_last && v_last;
    end
  end

  always_comb begin
    raw     = '0;
    raw.act = (vga_h < H_VIS) && (vga_v < V_VIS);
    raw.hs  = in_range(vga_h, HS_FIRST, HS_LAST);
    raw.vs  = in_range(vga_v, VS_FIRST, VS_LAST);
  end

  vga_delay_line #(.PIPE(PIPE)) u_dly (
    .clk   (clk),
    .reset (reset),
    .d     (raw),
    .q     (dly)
  );

  // Overlay pixels arrive one clock before this register, in step with dly.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      video_active <= 1'b0;
      rgb          <= BLACK;
    end else begin
      hsync        <= dly.hs ^ ~SYNC_POL;
      vsync        <= dly.vs ^ ~SYNC_POL;
      video_active <= dly.act;
      rgb          <= dly.act ? (pixel_on ? pixel_in : BG) : BLACK;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reduced rasters (PIPE=1 and PIPE=3) checked every
// clock against an arithmetic model, plus a full-size instance for line timing.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HV = 20, HF = 3, HS = 4, HB = 5, HT = HV + HF + HS + HB;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam color_t BG1 = BLUE;
  localparam color_t BG3 = BLACK;

  logic clk = 1'b0;
  logic reset = 1'b1;
  color_t pin1 = BLACK, pin3 = BLACK, pin0 = BLACK;
  logic   pon1 = 1'b0,  pon3 = 1'b0,  pon0 = 1'b0;

  coord_t h1, v1, h3, v3, h0, v0;
  logic   hs1, vs1, va1, fs1, hs3, vs3, va3, fs3, hs0, vs0, va0, fs0;
  color_t rgb1, rgb3, rgb0;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b1), .PIPE(1), .BG(BG1)) u1 (
    .clk(clk), .reset(reset), .vga_h(h1), .vga_v(v1), .pixel_in(pin1), .pixel_on(pon1),
    .hsync(hs1), .vsync(vs1), .rgb(rgb1), .video_active(va1), .frame_start(fs1));

  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .SYNC_POL(1'b0), .PIPE(3), .BG(BG3)) u3 (
    .clk(clk), .reset(reset), .vga_h(h3), .vga_v(v3), .pixel_in(pin3), .pixel_on(pon3),
    .hsync(hs3), .vsync(vs3), .rgb(rgb3), .video_active(va3), .frame_start(fs3));

  vga_timing_gen u0 (
    .clk(clk), .reset(reset), .vga_h(h0), .vga_v(v0), .pixel_in(pin0), .pixel_on(pon0),
    .hsync(hs0), .vsync(vs0), .rgb(rgb0), .video_active(va0), .frame_start(fs0));

  int checks = 0;
  int fails  = 0;
  int c = 0;  // clocks since the last reset edge

  typedef struct {
    int cyc; int h; int v; int hs; int vs; int fs;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at c=%0d: got %0d, want %0d", name, c, act, exp);
    end
  endtask

  // Reference raster: coordinate j clocks after reset, decoded by plain arithmetic.
  function automatic int mh(int j); return j % HT; endfunction
  function automatic int mv(int j); return (j / HT) % VT; endfunction
  function automatic bit m_act(int j); return mh(j) < HV && mv(j) < VV; endfunction
  function automatic bit m_hs(int j); return mh(j) >= HV + HF && mh(j) < HV + HF + HS; endfunction
  function automatic bit m_vs(int j); return mv(j) >= VV + VF && mv(j) < VV + VF + VS; endfunction
  function automatic bit hit(int j); return j >= 0 && mv(j) == 3 && mh(j) >= 10 && mh(j) <= 14; endfunction
  function automatic bit ov(int j); return j >= 0 && (hit(j) || mh(j) >= HV); endfunction

  // Outputs at clock c reflect coordinate c-P-1 and the pixel sampled at this edge.
  task automatic chk_out(input string tag, input int p, input bit sp, input logic hs,
                         input logic vs, input logic va, input color_t rgb,
                         input color_t bg, input color_t pin, input logic pon);
    bit a = 0, h = 0, v = 0;
    color_t e = BLACK;
    if (c >= p + 1) begin
      a = m_act(c - p - 1); h = m_hs(c - p - 1); v = m_vs(c - p - 1);
    end
    if (a) e = pon ? pin : bg;
    chk({tag, ".hsync"}, hs, h ? sp : !sp);
    chk({tag, ".vsync"}, vs, v ? sp : !sp);
    chk({tag, ".active"}, va, a);
    chk({tag, ".rgb"}, rgb, e);
  endtask

  task automatic tick();
    logic r = reset;
    color_t a1 = pin1, a3 = pin3;
    logic o1 = pon1, o3 = pon3;
    @(posedge clk); #1;
    if (r) c = 0; else c++;
    chk("u1.h", h1, mh(c)); chk("u1.v", v1, mv(c)); chk("u1.fs", fs1, c > 0 && c % FR == 0);
    chk("u3.h", h3, mh(c)); chk("u3.v", v3, mv(c)); chk("u3.fs", fs3, c > 0 && c % FR == 0);
    chk_out("u1", 1, 1'b1, hs1, vs1, va1, rgb1, BG1, a1, o1);
    chk_out("u3", 3, 1'b0, hs3, vs3, va3, rgb3, BG3, a3, o3);
    foreach (tbl[i]) if (tbl[i].cyc == c) begin
      chk("tbl.h", h1, tbl[i].h);   chk("tbl.v", v1, tbl[i].v);
      chk("tbl.hs", hs1, tbl[i].hs); chk("tbl.vs", vs1, tbl[i].vs);
      chk("tbl.fs", fs1, tbl[i].fs);
    end
  endtask

  initial begin
    int red1 = 0, red3 = 0, hcnt = 0, vcnt = 0, fscnt = 0, last_fs = -1;
    int f_hs1 = -1, f_hs3 = -1, f_va1 = -1, f_va3 = -1, h0cnt = 0, f_h0 = -1;

    tbl = '{'{0, 0, 0, 0, 0, 0},     '{1, 1, 0, 0, 0, 0},     '{24, 24, 0, 0, 0, 0},
            '{25, 25, 0, 1, 0, 0},   '{28, 28, 0, 1, 0, 0},   '{29, 29, 0, 0, 0, 0},
            '{31, 31, 0, 0, 0, 0},   '{32, 0, 1, 0, 0, 0},    '{257, 1, 8, 0, 0, 0},
            '{258, 2, 8, 0, 1, 0},   '{321, 1, 10, 0, 1, 0},  '{322, 2, 10, 0, 0, 0},
            '{416, 0, 0, 0, 0, 1},   '{417, 1, 0, 0, 0, 0}};

    // Reset held for 3 clocks with noise on the pixel inputs.
    for (int k = 0; k < 3; k++) begin
      pin1 = color_t'($urandom); pon1 = 1'($urandom);
      pin3 = color_t'($urandom); pon3 = 1'($urandom);
      tick();
      chk("u0.h", h0, 0); chk("u0.hsync", hs0, 0); chk("u0.vsync", vs0, 0);
      chk("u0.rgb", rgb0, 0); chk("u0.active", va0, 0); chk("u0.fs", fs0, 0);
    end
    reset = 1'b0;

    // Overlay answers its delayed coordinate: RED at h=10..14 of line 3,
    // GREEN claimed over the whole blanking interval (must stay black).
    for (int k = 0; k < 1100; k++) begin
      pon1 = ov(c - 1); pin1 = hit(c - 1) ? RED : GREEN;
      pon3 = ov(c - 3); pin3 = hit(c - 3) ? RED : GREEN;
      tick();
      if (c < FR) begin
        if (rgb1 == RED) red1++;
        if (rgb3 == RED) red3++;
        if (vs1) vcnt++;
      end
      if (c < HT && hs1) hcnt++;
      if (f_hs1 < 0 && hs1) f_hs1 = c;
      if (f_hs3 < 0 && !hs3) f_hs3 = c;
      if (f_va1 < 0 && va1) f_va1 = c;
      if (f_va3 < 0 && va3) f_va3 = c;
      if (fs1) begin
        fscnt++;
        if (last_fs >= 0) chk("fs.period", c - last_fs, FR);
        last_fs = c;
      end
      if (hs0) begin h0cnt++; if (f_h0 < 0) f_h0 = c; end
      if (c == VGA_H_TOTAL - 1) begin chk("u0.h.last", h0, 1039); chk("u0.v.line0", v0, 0); end
      if (c == VGA_H_TOTAL) begin chk("u0.h.wrap", h0, 0); chk("u0.v.line1", v0, 1); end
    end
    chk("red.count.p1", red1, 5);
    chk("red.count.p3", red3, 5);
    chk("hsync.width", hcnt, HS);
    chk("vsync.clocks", vcnt, VS * HT);
    chk("fs.count", fscnt, 2);
    chk("hsync.first.p1", f_hs1, HV + HF + 2);
    chk("hsync.shift", f_hs3 - f_hs1, 2);
    chk("active.shift", f_va3 - f_va1, 2);
    chk("u0.hsync.width", h0cnt, VGA_H_SYNC);
    chk("u0.hsync.first", f_h0, VGA_H_VISIBLE + VGA_H_FRONT + 2);

    // Mid-frame reset at h=10, v=4 with the overlay claiming every pixel.
    pon1 = 1'b1; pon3 = 1'b1; pin1 = WHITE; pin3 = WHITE;
    for (int k = 0; k < FR && (c % FR) != 4 * HT + 10; k++) tick();
    chk("rst.at.h", h1, 10);
    chk("rst.at.v", v1, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst.h", h1, 0); chk("rst.v", v1, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (c <= 1) chk("rst.blank.p1", rgb1, BLACK);
      if (c == 2) chk("rst.resume.p1", rgb1, WHITE);
      if (c <= 3) begin chk("rst.blank.p3", rgb3, BLACK); chk("rst.hs.p3", hs3, 1); end
    end

    // Random pixels with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 499) == 0);
      pin1 = color_t'($urandom); pon1 = 1'($urandom);
      pin3 = color_t'($urandom); pon3 = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
